// File: rtl/regimm_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : regimm_resolve_unit_if
// Purpose  : Input-beat and result handshake bundle for regimm_resolve_unit.
// Revision : 1.0
// ============================================================================
interface regimm_resolve_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_is_regimm;
    logic [4:0]        in_rt;
    logic [DATA_W-1:0] in_rs_val;
    logic [15:0]       in_imm;
    logic [ADDR_W-1:0] in_pc;

    logic              out_valid;
    logic              out_ready;
    logic              out_taken;
    logic [ADDR_W-1:0] out_target;
    logic              out_link_we;
    logic [ADDR_W-1:0] out_link_val;
    logic              out_trap;
    logic              out_annul;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_is_regimm, in_rt, in_rs_val, in_imm, in_pc,
        output in_ready,
        output out_valid, out_taken, out_target, out_link_we, out_link_val,
               out_trap, out_annul, out_illegal,
        input  out_ready
    );

    modport master (
        output in_valid, in_is_regimm, in_rt, in_rs_val, in_imm, in_pc,
        input  in_ready,
        input  out_valid, out_taken, out_target, out_link_we, out_link_val,
               out_trap, out_annul, out_illegal,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/regimm_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : regimm_resolve_unit
// Purpose  : Resolves REGIMM branches/traps, tracks likely delay-slot annulment,
//            and returns results through a 2-entry skid buffer.
// Revision : 1.0
// ============================================================================
module regimm_resolve_unit #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 32,
    parameter int ENABLE_TRAPS  = 1,
    parameter int ENABLE_LIKELY = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               flush,
    regimm_resolve_unit_if.slave    bus
);

    localparam logic [4:0] c_RT_BLTZ    = 5'b00000;
    localparam logic [4:0] c_RT_BGEZ    = 5'b00001;
    localparam logic [4:0] c_RT_BLTZL   = 5'b00010;
    localparam logic [4:0] c_RT_BGEZL   = 5'b00011;
    localparam logic [4:0] c_RT_TGEI    = 5'b01000;
    localparam logic [4:0] c_RT_TGEIU   = 5'b01001;
    localparam logic [4:0] c_RT_TLTI    = 5'b01010;
    localparam logic [4:0] c_RT_TLTIU   = 5'b01011;
    localparam logic [4:0] c_RT_TEQI    = 5'b01100;
    localparam logic [4:0] c_RT_TNEI    = 5'b01110;
    localparam logic [4:0] c_RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] c_RT_BGEZAL  = 5'b10001;
    localparam logic [4:0] c_RT_BLTZALL = 5'b10010;
    localparam logic [4:0] c_RT_BGEZALL = 5'b10011;

    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_LINK_STEP = ADDR_W'(8);

    typedef enum logic [0:0] {
        ST_NORMAL    = 1'b0,
        ST_SLOT_PEND = 1'b1
    } state_t;

    typedef struct packed {
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic              link_we;
        logic [ADDR_W-1:0] link_val;
        logic              trap;
        logic              annul;
        logic              illegal;
    } result_t;

    state_t            r_state;
    state_t            w_state_nxt;

    result_t           r_mem [0:1];
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [1:0]        r_count;
    logic              r_in_ready;

    logic [DATA_W-1:0] w_simm;
    logic [ADDR_W-1:0] w_br_off;
    logic              w_ltz;
    logic              w_is_branch;
    logic              w_is_likely;
    logic              w_is_link;
    logic              w_br_cond;
    logic              w_is_trap;
    logic              w_trap_cond;
    logic              w_illegal;
    logic              w_arm;
    result_t           w_res;
    result_t           w_head;

    logic              w_accept;
    logic              w_pop;
    logic [1:0]        w_count_nxt;

    assign w_simm   = {{(DATA_W-16){bus.in_imm[15]}}, bus.in_imm};
    assign w_br_off = {{(ADDR_W-18){bus.in_imm[15]}}, bus.in_imm, 2'b00};
    assign w_ltz    = bus.in_rs_val[DATA_W-1];

    // Sub-opcode decode, including parameter-disabled codes folding into illegal.
    always_comb begin
        w_is_branch = 1'b0;
        w_is_likely = 1'b0;
        w_is_link   = 1'b0;
        w_br_cond   = 1'b0;
        w_is_trap   = 1'b0;
        w_trap_cond = 1'b0;
        w_illegal   = 1'b0;
        case (bus.in_rt)
            c_RT_BLTZ:    begin w_is_branch = 1'b1; w_br_cond = w_ltz;  end
            c_RT_BGEZ:    begin w_is_branch = 1'b1; w_br_cond = !w_ltz; end
            c_RT_BLTZL:   begin w_is_branch = 1'b1; w_is_likely = 1'b1; w_br_cond = w_ltz;  end
            c_RT_BGEZL:   begin w_is_branch = 1'b1; w_is_likely = 1'b1; w_br_cond = !w_ltz; end
            c_RT_BLTZAL:  begin w_is_branch = 1'b1; w_is_link = 1'b1; w_br_cond = w_ltz;  end
            c_RT_BGEZAL:  begin w_is_branch = 1'b1; w_is_link = 1'b1; w_br_cond = !w_ltz; end
            c_RT_BLTZALL: begin
                w_is_branch = 1'b1; w_is_link = 1'b1; w_is_likely = 1'b1; w_br_cond = w_ltz;
            end
            c_RT_BGEZALL: begin
                w_is_branch = 1'b1; w_is_link = 1'b1; w_is_likely = 1'b1; w_br_cond = !w_ltz;
            end
            c_RT_TGEI:    begin w_is_trap = 1'b1; w_trap_cond = $signed(bus.in_rs_val) >= $signed(w_simm); end
            c_RT_TGEIU:   begin w_is_trap = 1'b1; w_trap_cond = bus.in_rs_val >= w_simm; end
            c_RT_TLTI:    begin w_is_trap = 1'b1; w_trap_cond = $signed(bus.in_rs_val) < $signed(w_simm); end
            c_RT_TLTIU:   begin w_is_trap = 1'b1; w_trap_cond = bus.in_rs_val < w_simm; end
            c_RT_TEQI:    begin w_is_trap = 1'b1; w_trap_cond = bus.in_rs_val == w_simm; end
            c_RT_TNEI:    begin w_is_trap = 1'b1; w_trap_cond = bus.in_rs_val != w_simm; end
            default:      w_illegal = 1'b1;
        endcase
        if (w_is_likely && (ENABLE_LIKELY == 0)) begin
            w_illegal   = 1'b1;
            w_is_branch = 1'b0;
            w_is_link   = 1'b0;
            w_is_likely = 1'b0;
        end
        if (w_is_trap && (ENABLE_TRAPS == 0)) begin
            w_illegal = 1'b1;
            w_is_trap = 1'b0;
        end
        if (!bus.in_is_regimm) begin
            w_is_branch = 1'b0;
            w_is_likely = 1'b0;
            w_is_link   = 1'b0;
            w_is_trap   = 1'b0;
            w_illegal   = 1'b0;
        end
    end

    always_comb begin
        w_res          = '0;
        w_res.taken    = w_is_branch && w_br_cond;
        w_res.target   = w_is_branch ? (bus.in_pc + c_PC_STEP + w_br_off) : '0;
        w_res.link_we  = w_is_link;
        w_res.link_val = w_is_link ? (bus.in_pc + c_LINK_STEP) : '0;
        w_res.trap     = w_is_trap && w_trap_cond;
        w_res.illegal  = w_illegal;
        // The beat in a pending likely slot is squashed regardless of its kind.
        if (r_state == ST_SLOT_PEND) begin
            w_res.taken   = 1'b0;
            w_res.link_we = 1'b0;
            w_res.trap    = 1'b0;
            w_res.illegal = 1'b0;
            w_res.annul   = 1'b1;
        end
    end

    assign w_arm = (r_state == ST_NORMAL) && w_is_likely && !w_br_cond;

    assign w_accept    = bus.in_valid && r_in_ready && !flush;
    assign w_pop       = (r_count != 2'd0) && bus.out_ready && !flush;
    assign w_count_nxt = r_count + {1'b0, w_accept} - {1'b0, w_pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_NORMAL;
        end else if (w_accept) begin
            w_state_nxt = w_arm ? ST_SLOT_PEND : ST_NORMAL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_res;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

    // Payload reads as zero whenever nothing is held, so stale entries never leak.
    assign w_head = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = (r_count != 2'd0);
    assign bus.out_taken    = w_head.taken;
    assign bus.out_target   = w_head.target;
    assign bus.out_link_we  = w_head.link_we;
    assign bus.out_link_val = w_head.link_val;
    assign bus.out_trap     = w_head.trap;
    assign bus.out_annul    = w_head.annul;
    assign bus.out_illegal  = w_head.illegal;

endmodule
`default_nettype wire
